alu_rs: RTL and testbench

Reservation station for the integer ALU function unit. It buffers dispatched ALU operations until both source operands are available, captures operand values from the common data bus (CDB), and issues one ready operation per cycle through a valid/ready handshake to the ALU's `opa`/`opb`/`alu_func` inputs. It sits between dispatch and the ALU, on the producer side of the ALU's operand interface.

---
 rtl/alu_rs_if.sv | 39 +++
 rtl/alu_rs.sv | 164 ++++++++++++++++
 tb/tb_alu_rs.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue signal bundle for the ALU reservation station.
// master: dispatch/CDB/ALU side; slave: the reservation station.
interface alu_rs_if #(
  parameter int unsigned TAG_W = 6
);
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_func;
  logic             disp_opa_rdy;
  logic             disp_opb_rdy;
  logic [TAG_W-1:0] disp_opa_tag;
  logic [TAG_W-1:0] disp_opb_tag;
  logic [31:0]      disp_opa;
  logic [31:0]      disp_opb;
  logic [TAG_W-1:0] disp_dest_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_opa;
  logic [31:0]      issue_opb;
  logic [3:0]       issue_func;
  logic [TAG_W-1:0] issue_dest_tag;

  modport master (
    output disp_valid, disp_func, disp_opa_rdy, disp_opb_rdy, disp_opa_tag,
           disp_opb_tag, disp_opa, disp_opb, disp_dest_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    input  disp_ready, issue_valid, issue_opa, issue_opb, issue_func, issue_dest_tag
  );

  modport slave (
    input  disp_valid, disp_func, disp_opa_rdy, disp_opb_rdy, disp_opa_tag,
           disp_opb_tag, disp_opa, disp_opb, disp_dest_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    output disp_ready, issue_valid, issue_opa, issue_opb, issue_func, issue_dest_tag
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers ops, wakes operands from the CDB, issues one per cycle.
// Optional macro ALU_RS_OLDEST_FIRST_EN selects the oldest ready entry via an age matrix.
module alu_rs #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] free_count,
  alu_rs_if.slave                rs
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [3:0]       func;
    logic [TAG_W-1:0] dest;
    logic             a_rdy;
    logic [TAG_W-1:0] a_tag;
    logic [31:0]      a_val;
    logic             b_rdy;
    logic [TAG_W-1:0] b_tag;
    logic [31:0]      b_val;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  logic               lock_q, lock_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic [CNT_W-1:0]   free_cnt;
  logic [IDX_W-1:0]   free_idx;
  logic [DEPTH-1:0]   cand;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;
  logic               issue_fire;
  logic               disp_fire;

  always_comb begin
    free_cnt = '0;
    free_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!ent_q[DEPTH-1-k].valid) free_idx = IDX_W'(DEPTH-1-k);
      if (!ent_q[k].valid) free_cnt = free_cnt + CNT_W'(1);
      cand[k] = ent_q[k].valid & ent_q[k].a_rdy & ent_q[k].b_rdy;
    end
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age_q[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic             older;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    older      = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      older = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++)
        if (j != i && cand[j] && age_q[j][i]) older = 1'b1;
      if (cand[i] && !older) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (disp_fire) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        age_d[free_idx][j] = 1'b0;
        if (IDX_W'(j) != free_idx) age_d[j][free_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (cand[DEPTH-1-k]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(DEPTH-1-k);
      end
    end
  end
`endif

  assign sel_idx    = lock_q ? lock_idx_q : pick_idx;
  assign sel_vld    = lock_q | pick_found;
  assign free_count = free_cnt;

  assign rs.disp_ready     = (free_cnt != '0);
  assign rs.issue_valid    = sel_vld & ~flush;
  assign rs.issue_opa      = rs.issue_valid ? ent_q[sel_idx].a_val : '0;
  assign rs.issue_opb      = rs.issue_valid ? ent_q[sel_idx].b_val : '0;
  assign rs.issue_func     = rs.issue_valid ? ent_q[sel_idx].func  : '0;
  assign rs.issue_dest_tag = rs.issue_valid ? ent_q[sel_idx].dest  : '0;

  assign issue_fire = rs.issue_valid & rs.issue_ready;
  assign disp_fire  = rs.disp_valid & rs.disp_ready & ~flush;

  // Dispatch targets a slot that is invalid in registered state, so it never overlaps the issuing entry
  always_comb begin
    ent_d      = ent_q;
    lock_d     = rs.issue_valid & ~rs.issue_ready;
    lock_idx_d = sel_idx;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rs.cdb_valid && ent_q[i].valid) begin
        if (!ent_q[i].a_rdy && ent_q[i].a_tag == rs.cdb_tag) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = rs.cdb_value;
        end
        if (!ent_q[i].b_rdy && ent_q[i].b_tag == rs.cdb_tag) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = rs.cdb_value;
        end
      end
      if (issue_fire && IDX_W'(i) == sel_idx) ent_d[i].valid = 1'b0;
      if (disp_fire && IDX_W'(i) == free_idx) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].func  = rs.disp_func;
        ent_d[i].dest  = rs.disp_dest_tag;
        ent_d[i].a_tag = rs.disp_opa_tag;
        ent_d[i].b_tag = rs.disp_opb_tag;
        ent_d[i].a_rdy = rs.disp_opa_rdy |
                         (rs.cdb_valid && rs.disp_opa_tag == rs.cdb_tag);
        ent_d[i].a_val = rs.disp_opa_rdy ? rs.disp_opa : rs.cdb_value;
        ent_d[i].b_rdy = rs.disp_opb_rdy |
                         (rs.cdb_valid && rs.disp_opb_tag == rs.cdb_tag);
        ent_d[i].b_val = rs.disp_opb_rdy ? rs.disp_opb : rs.cdb_value;
      end
      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ent_q      <= ent_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed, table-driven bench for alu_rs (DEPTH=8, TAG_W=6) plus hand-written multi-cycle sequences.
module tb_alu_rs;
  logic       clock;
  logic       reset_n;
  logic       flush;
  logic [3:0] free_count;
  int         checks;
  int         failures;

  alu_rs_if #(.TAG_W(6)) rs_if ();

  alu_rs #(.DEPTH(8), .TAG_W(6)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .free_count (free_count),
    .rs         (rs_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int dv, fn, ar, at, a, br, bt, b, dst, cv, ct, cval;
    int eiv, ea, eb, ef, ed, efree;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string n, input int eiv, ea, eb, ef, ed, efree);
    check({n, ".issue_valid"}, 32'(rs_if.issue_valid), 32'(eiv));
    check({n, ".issue_opa"},   rs_if.issue_opa,        32'(ea));
    check({n, ".issue_opb"},   rs_if.issue_opb,        32'(eb));
    check({n, ".issue_func"},  32'(rs_if.issue_func),  32'(ef));
    check({n, ".issue_dest"},  32'(rs_if.issue_dest_tag), 32'(ed));
    check({n, ".free_count"},  32'(free_count),        32'(efree));
    check({n, ".disp_ready"},  32'(rs_if.disp_ready),  32'(efree != 0));
  endtask

  task automatic idle();
    rs_if.disp_valid    = 1'b0;
    rs_if.disp_func     = '0;
    rs_if.disp_opa_rdy  = 1'b0;
    rs_if.disp_opb_rdy  = 1'b0;
    rs_if.disp_opa_tag  = '0;
    rs_if.disp_opb_tag  = '0;
    rs_if.disp_opa      = '0;
    rs_if.disp_opb      = '0;
    rs_if.disp_dest_tag = '0;
    rs_if.cdb_valid     = 1'b0;
    rs_if.cdb_tag       = '0;
    rs_if.cdb_value     = '0;
    rs_if.issue_ready   = 1'b1;
    flush               = 1'b0;
  endtask

  task automatic disp(input int fn, ar, at, a, br, bt, b, dst);
    rs_if.disp_valid    = 1'b1;
    rs_if.disp_func     = 4'(fn);
    rs_if.disp_opa_rdy  = 1'(ar);
    rs_if.disp_opa_tag  = 6'(at);
    rs_if.disp_opa      = 32'(a);
    rs_if.disp_opb_rdy  = 1'(br);
    rs_if.disp_opb_tag  = 6'(bt);
    rs_if.disp_opb      = 32'(b);
    rs_if.disp_dest_tag = 6'(dst);
  endtask

  task automatic cdb(input int tag, val);
    rs_if.cdb_valid = 1'b1;
    rs_if.cdb_tag   = 6'(tag);
    rs_if.cdb_value = 32'(val);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle();

    //            dv fn ar at a     br bt b     dst cv ct cval   eiv ea    eb    ef ed efree
    tbl[0]  = '{1, 0, 1, 0, 5,    1, 0, 7,    3,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[1]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     1, 5,    7,    0, 3, 7};
    tbl[2]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[3]  = '{1, 1, 0, 9, 0,    1, 0, 2,    4,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[4]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     0, 0,    0,    0, 0, 7};
    tbl[5]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  1, 9, 'h10,  0, 0,    0,    0, 0, 7};
    tbl[6]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     1, 'h10, 2,    1, 4, 7};
    tbl[7]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[8]  = '{1, 2, 0, 9, 0,    1, 0, 'h30, 5,  1, 9, 'h20,  0, 0,    0,    0, 0, 8};
    tbl[9]  = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     1, 'h20, 'h30, 2, 5, 7};
    tbl[10] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[11] = '{1, 3, 0, 12, 0,   0, 12, 0,   6,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[12] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  1, 11, 'h99, 0, 0,    0,    0, 0, 7};
    tbl[13] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  1, 12, 'h44, 0, 0,    0,    0, 0, 7};
    tbl[14] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     1, 'h44, 'h44, 3, 6, 7};
    tbl[15] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[16] = '{1, 0, 1, 0, 1,    1, 0, 2,    7,  0, 0, 0,     0, 0,    0,    0, 0, 8};
    tbl[17] = '{1, 4, 1, 0, 3,    1, 0, 4,    8,  0, 0, 0,     1, 1,    2,    0, 7, 7};
    tbl[18] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     1, 3,    4,    4, 8, 7};
    tbl[19] = '{0, 0, 0, 0, 0,    0, 0, 0,    0,  0, 0, 0,     0, 0,    0,    0, 0, 8};

    @(negedge clock);
    #1 chk_out("reset", 0, 0, 0, 0, 0, 8);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      idle();
      if (tbl[i].dv != 0)
        disp(tbl[i].fn, tbl[i].ar, tbl[i].at, tbl[i].a, tbl[i].br, tbl[i].bt, tbl[i].b, tbl[i].dst);
      if (tbl[i].cv != 0) cdb(tbl[i].ct, tbl[i].cval);
      #1 chk_out($sformatf("vec%0d", i), tbl[i].eiv, tbl[i].ea, tbl[i].eb,
                 tbl[i].ef, tbl[i].ed, tbl[i].efree);
    end

    // Fill with issue stalled: entry 0 locks, then the station fills and drops an extra dispatch.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      idle();
      rs_if.issue_ready = 1'b0;
      disp(i, 1, 0, 100 + i, 1, 0, 200 + i, 10 + i);
      #1 check($sformatf("fill%0d.free", i), 32'(free_count), 32'(8 - i));
      if (i > 0) check($sformatf("fill%0d.hold_opa", i), rs_if.issue_opa, 32'd100);
    end
    @(negedge clock);
    idle();
    rs_if.issue_ready = 1'b0;
    disp(9, 1, 0, 999, 1, 0, 999, 33);
    #1 chk_out("full_drop", 1, 100, 200, 0, 10, 0);
    @(negedge clock);
    idle();
    rs_if.issue_ready = 1'b0;
    #1 chk_out("full_hold", 1, 100, 200, 0, 10, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      idle();
      #1 chk_out($sformatf("drain%0d", i), 1, 100 + i, 200 + i, i, 10 + i, i);
    end
    @(negedge clock);
    idle();
    #1 chk_out("drained", 0, 0, 0, 0, 0, 8);

    // Select order: op placed in entry 5 before op placed in entry 2, woken together.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      idle();
      disp(0, 0, 40 + i, 0, 1, 0, 1, 10 + i);
      #1 check($sformatf("sel_fill%0d.iv", i), 32'(rs_if.issue_valid), 32'd0);
    end
    @(negedge clock); idle(); cdb(45, 'h45);
    #1 check("sel_c1.free", 32'(free_count), 32'd0);
    @(negedge clock); idle();
    #1 chk_out("sel_c2", 1, 'h45, 1, 0, 15, 0);
    @(negedge clock); idle(); disp(5, 0, 50, 0, 1, 0, 1, 55);
    #1 chk_out("sel_c3", 0, 0, 0, 0, 0, 1);
    @(negedge clock); idle(); cdb(42, 'h42);
    #1 chk_out("sel_c4", 0, 0, 0, 0, 0, 0);
    @(negedge clock); idle();
    #1 chk_out("sel_c5", 1, 'h42, 1, 0, 12, 0);
    @(negedge clock); idle(); disp(2, 0, 50, 0, 1, 0, 2, 52);
    #1 chk_out("sel_c6", 0, 0, 0, 0, 0, 1);
    @(negedge clock); idle(); cdb(50, 'h50);
    #1 chk_out("sel_c7", 0, 0, 0, 0, 0, 0);
`ifdef ALU_RS_OLDEST_FIRST_EN
    @(negedge clock); idle();
    #1 chk_out("sel_first", 1, 'h50, 1, 5, 55, 0);
    @(negedge clock); idle();
    #1 chk_out("sel_second", 1, 'h50, 2, 2, 52, 1);
`else
    @(negedge clock); idle();
    #1 chk_out("sel_first", 1, 'h50, 2, 2, 52, 0);
    @(negedge clock); idle();
    #1 chk_out("sel_second", 1, 'h50, 1, 5, 55, 1);
`endif
    @(negedge clock); idle(); flush = 1'b1;
    #1 chk_out("sel_flush", 0, 0, 0, 0, 0, 2);
    @(negedge clock); idle();
    #1 chk_out("sel_after_flush", 0, 0, 0, 0, 0, 8);

    // Flush with four valid entries and a locked, visible issue.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle();
      rs_if.issue_ready = 1'b0;
      disp(1, 1, 0, 'h200 + i, 1, 0, 'h300 + i, 20 + i);
      #1 check($sformatf("fl_fill%0d.free", i), 32'(free_count), 32'(8 - i));
    end
    @(negedge clock); idle(); rs_if.issue_ready = 1'b0;
    #1 chk_out("fl_pre", 1, 'h200, 'h300, 1, 20, 4);
    @(negedge clock); idle(); flush = 1'b1;
    #1 chk_out("fl_cycle", 0, 0, 0, 0, 0, 4);
    @(negedge clock); idle();
    #1 chk_out("fl_post", 0, 0, 0, 0, 0, 8);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      idle();
      rs_if.issue_ready = 1'b0;
      disp(6, 1, 0, 'h300 + i, 1, 0, 'h400 + i, 30 + i);
    end
    @(negedge clock); idle(); rs_if.issue_ready = 1'b0;
    #1 chk_out("rst_pre", 1, 'h300, 'h400, 6, 30, 6);
    #2 reset_n = 1'b0;
    #1 chk_out("rst_mid", 0, 0, 0, 0, 0, 8);
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    @(negedge clock);
    #1 chk_out("rst_post", 0, 0, 0, 0, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
